alu_pipe_mc: RTL and testbench

//  Parametrised, registered successor of the 32-bit combinational ALU. Adds valid/ready

---
 rtl/alu_pipe_mc.sv | 159 +++++++++++++++
 tb/tb_alu_pipe_mc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_mc.sv
// Registered ALU with valid/ready handshakes, an iterative shift-add multiply, SLTU,
// signed overflow and a zero flag. One operation in flight; results held until accepted.
// state  | meaning
// IDLE   | waiting for an operation, in_ready_o high
// MUL    | shift-add multiply, one multiplier bit per cycle, busy_o high
// HOLD   | result presented on out_valid_o until out_ready_i
module alu_pipe_mc #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] mux_out_a_i,
    input  logic [WIDTH-1:0] mux_out_b_i,
    input  logic [3:0]       alu_ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_out_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             busy_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d, res_q, res_d;
    logic [WIDTH-1:0]   op_res, sum, diff;
    logic [SHW-1:0]     cnt_q, cnt_d, shamt;
    logic               ovf_q, ovf_d, zero_q, zero_d;
    logic               op_ovf, is_mul, accept;

    always_comb begin
        shamt  = mux_out_a_i[SHW-1:0];
        sum    = mux_out_a_i + mux_out_b_i;
        diff   = mux_out_a_i - mux_out_b_i;
        op_res = '0;
        op_ovf = 1'b0;
        case (alu_ctrl_i)
            OP_AND:  op_res = mux_out_a_i & mux_out_b_i;
            OP_ADD: begin
                op_res = sum;
                op_ovf = (mux_out_a_i[MSB] == mux_out_b_i[MSB]) && (sum[MSB] != mux_out_a_i[MSB]);
            end
            OP_SUB: begin
                op_res = diff;
                op_ovf = (mux_out_a_i[MSB] != mux_out_b_i[MSB]) && (diff[MSB] != mux_out_a_i[MSB]);
            end
            OP_OR:   op_res = mux_out_a_i | mux_out_b_i;
            OP_SLL:  op_res = mux_out_b_i << shamt;
            OP_SRL:  op_res = mux_out_b_i >> shamt;
            OP_SRA:  op_res = $signed(mux_out_b_i) >>> shamt;
            OP_SLT:  op_res[0] = $signed(mux_out_a_i) < $signed(mux_out_b_i);
            OP_SLTU: op_res[0] = mux_out_a_i < mux_out_b_i;
            default: ;
        endcase
    end

    // With MUL_EN cleared the MUL opcode falls through to the undefined-opcode path.
    assign is_mul   = MUL_EN && (alu_ctrl_i == OP_MUL);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        accept      = 1'b0;

        unique case (state_q)
            S_IDLE: in_ready_o = 1'b1;
            S_MUL: begin
                busy_o   = 1'b1;
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    res_d   = acc_step[WIDTH-1:0];
                    ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_step[WIDTH-1:0] == '0);
                end
            end
            S_HOLD: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        accept = in_ready_o && in_valid_i;
        if (accept) begin
            if (is_mul) begin
                state_d  = S_MUL;
                mcand_d  = {{WIDTH{1'b0}}, mux_out_a_i};
                mplier_d = mux_out_b_i;
                acc_d    = '0;
                cnt_d    = SHW'(WIDTH - 1);
            end else begin
                state_d = S_HOLD;
                res_d   = op_res;
                ovf_d   = op_ovf;
                zero_d  = (op_res == '0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign alu_out_o  = res_q;
    assign overflow_o = ovf_q;
    assign zero_o     = zero_q;

endmodule

// File: tb/tb_alu_pipe_mc.sv
// Scoreboard bench for alu_pipe_mc: a 32-bit instance with MUL and an 8-bit instance without.
module tb_alu_pipe_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_ovf, w_zero, w_busy;
    logic [31:0] w_a, w_b, w_res;
    logic [3:0]  w_op;
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_ovf, n_zero, n_busy;
    logic [7:0]  n_a, n_b, n_res;
    logic [3:0]  n_op;

    alu_pipe_mc #(.WIDTH(32), .MUL_EN(1'b1)) u_wide (
        .clk_i(clk), .rst_i(rst), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
        .mux_out_a_i(w_a), .mux_out_b_i(w_b), .alu_ctrl_i(w_op), .out_valid_o(w_out_valid),
        .out_ready_i(w_out_ready), .alu_out_o(w_res), .overflow_o(w_ovf), .zero_o(w_zero),
        .busy_o(w_busy));

    alu_pipe_mc #(.WIDTH(8), .MUL_EN(1'b0)) u_narrow (
        .clk_i(clk), .rst_i(rst), .in_valid_i(n_in_valid), .in_ready_o(n_in_ready),
        .mux_out_a_i(n_a), .mux_out_b_i(n_b), .alu_ctrl_i(n_op), .out_valid_o(n_out_valid),
        .out_ready_i(n_out_ready), .alu_out_o(n_res), .overflow_o(n_ovf), .zero_o(n_zero),
        .busy_o(n_busy));

    typedef struct {
        longint unsigned r;
        bit              o;
        bit              z;
    } exp_t;

    exp_t q_w[$];
    exp_t q_n[$];
    exp_t e_w, e_n;
    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic longint sext(input longint unsigned v, input int w);
        longint t;
        t = $signed(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    // Reference: plain integer arithmetic on sign-extended / masked values.
    function automatic void model(input int w, input bit mul_en, input logic [3:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned r, output bit o);
        longint unsigned mask, full;
        longint          sa, sb, s, maxs, mins;
        int              sh;
        mask = (64'd1 << w) - 64'd1;
        sa   = sext(a, w);
        sb   = sext(b, w);
        maxs = (64'sd1 <<< (w - 1)) - 64'sd1;
        mins = -maxs - 64'sd1;
        sh   = int'(a % longint'(w));
        r    = 0;
        o    = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: begin s = sa + sb; r = s & mask; o = (s > maxs) || (s < mins); end
            4'h2: begin s = sa - sb; r = s & mask; o = (s > maxs) || (s < mins); end
            4'h3: r = a | b;
            4'h5: r = (b << sh) & mask;
            4'h6: r = b >> sh;
            4'h8: begin s = sb >>> sh; r = s & mask; end
            4'h9: r = (sa < sb) ? 1 : 0;
            4'hA: r = (a < b) ? 1 : 0;
            4'hC: if (mul_en) begin full = a * b; r = full & mask; o = (full >> w) != 0; end
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && w_out_valid && w_out_ready) begin
            if (q_w.size() == 0) check("w_stray_result", 1, 0);
            else begin
                e_w = q_w.pop_front();
                check("w_result", w_res, e_w.r);
                check("w_overflow", w_ovf, e_w.o);
                check("w_zero", w_zero, e_w.z);
            end
        end
        if (!rst && n_out_valid && n_out_ready) begin
            if (q_n.size() == 0) check("n_stray_result", 1, 0);
            else begin
                e_n = q_n.pop_front();
                check("n_result", n_res, e_n.r);
                check("n_overflow", n_ovf, e_n.o);
                check("n_zero", n_zero, e_n.z);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) begin
            w_out_ready = 1'($urandom_range(0, 1));
            n_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input bit narrow, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit has_exp, input longint unsigned er,
                         input bit eo);
        exp_t            e;
        longint unsigned r;
        bit              o;
        int              n;
        if (narrow) begin n_op = op; n_a = a[7:0]; n_b = b[7:0]; n_in_valid = 1'b1; end
        else begin w_op = op; w_a = a; w_b = b; w_in_valid = 1'b1; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(narrow ? n_in_ready : w_in_ready) && n < 200);
        if (!(narrow ? n_in_ready : w_in_ready)) check("accept_timeout", 0, 1);
        else begin
            if (has_exp) begin
                r = er;
                o = eo;
            end else if (narrow) model(8, 1'b0, op, {56'd0, a[7:0]}, {56'd0, b[7:0]}, r, o);
            else model(32, 1'b1, op, {32'd0, a}, {32'd0, b}, r, o);
            e = '{r, o, r == 0};
            if (narrow) q_n.push_back(e);
            else q_w.push_back(e);
        end
        @(posedge clk);
        #1;
        if (narrow) n_in_valid = 1'b0;
        else w_in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit narrow, input string name, input int exp_lat);
        int n, busy_cycles;
        bit v;
        n = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            n++;
            v = narrow ? n_out_valid : w_out_valid;
            if (!v && (narrow ? (n_busy && !n_in_ready) : (w_busy && !w_in_ready)))
                busy_cycles++;
        end while (!v && n < 100);
        check({name, "_latency"}, n, exp_lat);
        if (exp_lat > 1) check({name, "_busy_cycles"}, busy_cycles, exp_lat - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        w_out_ready = 1'b1;
        n_out_ready = 1'b1;
        while ((q_w.size() != 0 || q_n.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q_w.size() + q_n.size(), 0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 40);
            default: return $urandom();
        endcase
    endfunction

    logic [3:0] ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC,
                            4'h4, 4'hF, 4'h7};

    initial begin
        int stray;
        rst = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_op = '0; w_out_ready = 1'b1;
        n_in_valid = 1'b0; n_a = '0; n_b = '0; n_op = '0; n_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_w_out_valid", w_out_valid, 0);
        check("rst_w_in_ready", w_in_ready, 1);
        check("rst_w_busy", w_busy, 0);
        check("rst_w_alu_out", w_res, 0);
        check("rst_w_overflow", w_ovf, 0);
        check("rst_w_zero", w_zero, 0);
        check("rst_n_out_valid", n_out_valid, 0);
        check("rst_n_in_ready", n_in_ready, 1);
        @(posedge clk);
        #1;

        issue(0, 4'h1, 32'h7FFF_FFFF, 32'h1, 1, 64'h8000_0000, 1);
        wait_valid(0, "add_ovf", 1);
        issue(0, 4'h2, 32'd5, 32'd7, 1, 64'hFFFF_FFFE, 0);
        wait_valid(0, "sub_neg", 1);
        issue(0, 4'h9, 32'hFFFF_FFFF, 32'd1, 1, 64'd1, 0);
        wait_valid(0, "slt", 1);
        issue(0, 4'hA, 32'hFFFF_FFFF, 32'd1, 1, 64'd0, 0);
        wait_valid(0, "sltu", 1);
        issue(0, 4'h8, 32'd36, 32'h8000_0000, 1, 64'hF800_0000, 0);
        wait_valid(0, "sra", 1);
        issue(0, 4'h6, 32'd36, 32'h8000_0000, 1, 64'h0800_0000, 0);
        wait_valid(0, "srl", 1);
        issue(0, 4'hF, 32'h1234, 32'h5678, 1, 64'd0, 0);
        wait_valid(0, "undef_op", 1);
        issue(0, 4'hC, 32'h0001_0000, 32'h0001_0000, 1, 64'd0, 1);
        w_a = $urandom();
        w_b = $urandom();
        wait_valid(0, "mul_ovf", 33);
        issue(0, 4'hC, 32'd7, 32'd6, 1, 64'd42, 0);
        wait_valid(0, "mul_small", 33);

        w_out_ready = 1'b0;
        issue(0, 4'h2, 32'd3, 32'd3, 1, 64'd0, 0);
        wait_valid(0, "sub_zero", 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", w_out_valid, 1);
            check("hold_in_ready", w_in_ready, 0);
            check("hold_alu_out", w_res, 0);
            check("hold_zero", w_zero, 1);
        end
        @(posedge clk);
        #1 w_out_ready = 1'b1;
        issue(0, 4'h9, 32'hFFFF_FFFF, 32'd1, 1, 64'd1, 0);
        wait_valid(0, "back_to_back", 1);

        issue(0, 4'hC, 32'h0001_0000, 32'h0001_0000, 1, 64'd0, 1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        q_w.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_mul_rst_out_valid", w_out_valid, 0);
        check("mid_mul_rst_busy", w_busy, 0);
        check("mid_mul_rst_in_ready", w_in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (w_out_valid) stray++;
        end
        check("no_stray_after_rst", stray, 0);
        @(posedge clk);
        #1;

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(0, ops[$urandom_range(0, 12)], rand_operand(), rand_operand(), 0, 0, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        @(posedge clk);
        #1;

        issue(1, 4'h1, 32'h7F, 32'h1, 1, 64'h80, 1);
        wait_valid(1, "n_add_ovf", 1);
        issue(1, 4'hC, 32'h10, 32'h10, 1, 64'd0, 0);
        wait_valid(1, "n_mul_disabled", 1);
        issue(1, 4'h2, 32'd5, 32'd7, 1, 64'hFE, 0);
        wait_valid(1, "n_sub_neg", 1);
        issue(1, 4'h8, 32'd12, 32'h80, 1, 64'hF8, 0);
        wait_valid(1, "n_sra", 1);

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(1, ops[$urandom_range(0, 12)], rand_operand(), rand_operand(), 0, 0, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
